// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings and types for the EX-stage hazard controller
package cpu_ctrl_pkg;

  localparam logic [1:0] FWD_RF       = 2'b00;
  localparam logic [1:0] FWD_EX       = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
  localparam logic [1:0] FWD_MEM_DATA = 2'b11;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic       wreg;
    logic       mem2reg;
  } stage_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - per-operand forward source select from EX/MEM destination info
module fwd_select
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       src_use,
  input  logic [4:0] ex_rd,
  input  logic       ex_wreg,
  input  logic       ex_mem2reg,
  input  logic [4:0] mem_rd,
  input  logic       mem_wreg,
  input  logic       mem_mem2reg,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    // A load in EX has no data yet, so it never wins; the load-use stall covers it.
    if (src_use && src != 5'd0) begin
      if (ex_wreg && !ex_mem2reg && ex_rd == src) begin
        sel = FWD_EX;
      end else if (mem_wreg && mem_rd == src) begin
        sel = mem_mem2reg ? FWD_MEM_DATA : FWD_MEM_ALU;
      end
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// rtl/ex_hazard_ctrl.sv - EX-stage hazard control: forwarding, load-use stall, MDU sequencing
module ex_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_useRs,
  input  logic       id_useRt,
  input  logic [4:0] id_rd,
  input  logic       id_wreg,
  input  logic       id_mem2reg,
  input  logic       id_store,
  input  logic       id_mduOp,
  input  logic       mdu_done,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB,
  output logic       ex_forward_memory,
  output logic       pcWriteEnable,
  output logic       ifidWriteEnable,
  output logic       idexWriteEnable,
  output logic       idexBubble,
  output logic       mdu_start,
  output logic       mdu_timeout
);

  localparam int CW = (MDU_MAX_CYCLES > 1) ? $clog2(MDU_MAX_CYCLES) : 1;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  stage_t        trk_q [3];
  stage_t        trk_d [3];
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdu_start_q, mdu_start_d;
  logic          mdu_timeout_q, mdu_timeout_d;
  logic          efm_q, efm_d;
  logic          run;
  logic          load_use;

  fwd_select u_fwd_a (
    .src        (id_rs),
    .src_use    (id_useRs),
    .ex_rd      (trk_q[0].rd),
    .ex_wreg    (trk_q[0].wreg),
    .ex_mem2reg (trk_q[0].mem2reg),
    .mem_rd     (trk_q[1].rd),
    .mem_wreg   (trk_q[1].wreg),
    .mem_mem2reg(trk_q[1].mem2reg),
    .sel        (fwdA)
  );

  fwd_select u_fwd_b (
    .src        (id_rt),
    .src_use    (id_useRt),
    .ex_rd      (trk_q[0].rd),
    .ex_wreg    (trk_q[0].wreg),
    .ex_mem2reg (trk_q[0].mem2reg),
    .mem_rd     (trk_q[1].rd),
    .mem_wreg   (trk_q[1].wreg),
    .mem_mem2reg(trk_q[1].mem2reg),
    .sel        (fwdB)
  );

  always_comb begin
    run      = (state_q == RUN);
    // Store data on rt is fed later from MEM, so it does not count as a use here.
    load_use = run && trk_q[0].mem2reg && trk_q[0].rd != 5'd0 &&
               ((id_useRs && id_rs == trk_q[0].rd) ||
                (id_useRt && id_rt == trk_q[0].rd && !id_store));

    pcWriteEnable   = run && !load_use;
    ifidWriteEnable = run && !load_use;
    idexWriteEnable = run;
    idexBubble      = load_use;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mdu_start_d   = 1'b0;
    mdu_timeout_d = mdu_timeout_q;
    efm_d         = 1'b0;
    trk_d         = trk_q;

    if (run) begin
      if (id_valid && !load_use) begin
        trk_d[0] = '{rd: id_rd, wreg: id_wreg, mem2reg: id_mem2reg};
      end else begin
        trk_d[0] = '0;
      end
      trk_d[1] = trk_q[0];
      trk_d[2] = trk_q[1];

      efm_d = id_valid && id_store && !load_use && trk_q[0].wreg && trk_q[0].mem2reg &&
              trk_q[0].rd != 5'd0 && id_rt == trk_q[0].rd;

      if (id_valid && id_mduOp && !load_use) begin
        state_d     = MDU_WAIT;
        cnt_d       = '0;
        mdu_start_d = 1'b1;
      end
    end else begin
      // The MDU op stays parked in EX while bubbles drain down the pipe.
      trk_d[1] = '0;
      trk_d[2] = trk_q[1];
      cnt_d    = cnt_q + 1'b1;
      if (mdu_done) begin
        state_d = RUN;
      end else if (cnt_q == CW'(MDU_MAX_CYCLES - 1)) begin
        state_d       = RUN;
        mdu_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      mdu_start_q   <= 1'b0;
      mdu_timeout_q <= 1'b0;
      efm_q         <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mdu_start_q   <= mdu_start_d;
      mdu_timeout_q <= mdu_timeout_d;
      efm_q         <= efm_d;
      trk_q         <= trk_d;
    end
  end

  assign ex_forward_memory = efm_q;
  assign mdu_start         = mdu_start_q;
  assign mdu_timeout       = mdu_timeout_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb/tb_ex_hazard_ctrl.sv - scoreboard bench for ex_hazard_ctrl (MDU_MAX_CYCLES = 8)
module tb_ex_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_useRs, id_useRt, id_wreg, id_mem2reg, id_store, id_mduOp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       mdu_done;
  logic [1:0] fwdA, fwdB;
  logic       ex_forward_memory, pcWriteEnable, ifidWriteEnable, idexWriteEnable;
  logic       idexBubble, mdu_start, mdu_timeout;

  typedef struct {
    string       name;
    logic [10:0] v;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  ex_hazard_ctrl #(.MDU_MAX_CYCLES(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_valid         (id_valid),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .id_useRs         (id_useRs),
    .id_useRt         (id_useRt),
    .id_rd            (id_rd),
    .id_wreg          (id_wreg),
    .id_mem2reg       (id_mem2reg),
    .id_store         (id_store),
    .id_mduOp         (id_mduOp),
    .mdu_done         (mdu_done),
    .fwdA             (fwdA),
    .fwdB             (fwdB),
    .ex_forward_memory(ex_forward_memory),
    .pcWriteEnable    (pcWriteEnable),
    .ifidWriteEnable  (ifidWriteEnable),
    .idexWriteEnable  (idexWriteEnable),
    .idexBubble       (idexBubble),
    .mdu_start        (mdu_start),
    .mdu_timeout      (mdu_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Layout: {fwdA, fwdB, pc, ifid, idex, bubble, start, timeout, ex_forward_memory}
  function automatic logic [10:0] ev(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic pc, input logic ifid, input logic idex,
                                     input logic bub, input logic st, input logic tmo,
                                     input logic efm);
    return {fa, fb, pc, ifid, idex, bub, st, tmo, efm};
  endfunction

  function automatic logic [10:0] obs();
    return {fwdA, fwdB, pcWriteEnable, ifidWriteEnable, idexWriteEnable, idexBubble,
            mdu_start, mdu_timeout, ex_forward_memory};
  endfunction

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic wr, input logic m2r, input logic st, input logic mdu);
    id_valid = v; id_rs = rs; id_rt = rt; id_useRs = urs; id_useRt = urt;
    id_rd = rd; id_wreg = wr; id_mem2reg = m2r; id_store = st; id_mduOp = mdu;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle();
    step(); step(); step();
  endtask

  task automatic test_reset();
    rst = 1'b1; mdu_done = 1'b0; idle();
    step(); step();
    sb.push_back('{"reset", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fwd_ex_mem();
    set_id(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step();
    set_id(1, 1, 0, 1, 0, 5, 1, 0, 0, 0);
    sb.push_back('{"fwd_ex", ev(2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    set_id(1, 1, 5, 1, 1, 6, 1, 0, 0, 0);
    sb.push_back('{"fwd_mem_alu", ev(2'b10, 2'b01, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    step();
    set_id(1, 2, 0, 1, 0, 6, 1, 0, 0, 0);
    sb.push_back('{"load_use_stall", ev(2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    sb.push_back('{"load_use_fwd11", ev(2'b11, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_store_after_load();
    set_id(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    step();
    set_id(1, 7, 3, 1, 1, 0, 0, 0, 1, 0);
    sb.push_back('{"store_no_stall", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    idle();
    sb.push_back('{"store_efm_set", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 1)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    sb.push_back('{"store_efm_clear", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_zero_and_priority();
    set_id(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    set_id(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    sb.push_back('{"reg0_no_fwd", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    set_id(0, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    step();
    set_id(1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
    sb.push_back('{"invalid_no_fwd", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step();
    set_id(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step();
    set_id(1, 4, 4, 1, 1, 0, 0, 0, 0, 0);
    sb.push_back('{"ex_beats_mem", ev(2'b01, 2'b01, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_mdu_done();
    set_id(1, 0, 0, 0, 0, 8, 1, 0, 0, 1);
    sb.push_back('{"mdu_issue", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    idle();
    for (int i = 1; i <= 5; i++) begin
      mdu_done = (i == 5);
      sb.push_back('{$sformatf("mdu_wait%0d", i), ev(2'b00, 2'b00, 0, 0, 0, 0, i == 1, 0, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
    mdu_done = 1'b0;
    set_id(1, 8, 0, 1, 0, 9, 1, 0, 0, 0);
    sb.push_back('{"mdu_resume_ex_held", ev(2'b01, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_done_ignored();
    idle();
    mdu_done = 1'b1;
    sb.push_back('{"done_in_run", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    mdu_done = 1'b0;
    sb.push_back('{"done_in_run_after", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
  endtask

  task automatic test_done_on_timeout_cycle();
    set_id(1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    step();
    idle();
    for (int i = 1; i <= 8; i++) begin
      mdu_done = (i == 8);
      sb.push_back('{$sformatf("late_done_wait%0d", i), ev(2'b00, 2'b00, 0, 0, 0, 0, i == 1, 0, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
    mdu_done = 1'b0;
    sb.push_back('{"late_done_no_timeout", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    flush();
  endtask

  task automatic test_timeout();
    set_id(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);
    step();
    idle();
    for (int i = 1; i <= 8; i++) begin
      sb.push_back('{$sformatf("timeout_wait%0d", i), ev(2'b00, 2'b00, 0, 0, 0, 0, i == 1, 0, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{$sformatf("timeout_sticky%0d", i), ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
    flush();
  endtask

  task automatic test_rst_mid_mdu();
    set_id(1, 0, 0, 0, 0, 12, 1, 0, 0, 1);
    step();
    idle();
    for (int i = 1; i <= 2; i++) begin
      sb.push_back('{$sformatf("rst_mdu_wait%0d", i), ev(2'b00, 2'b00, 0, 0, 0, 0, i == 1, 1, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
    rst = 1'b1;
    sb.push_back('{"rst_mdu_wait3", ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    step();
    sb.push_back('{"rst_applied", ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
    @(negedge clk);
    e = sb.pop_front(); vectors++;
    if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
    rst = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{$sformatf("post_rst%0d", i), ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 0, 0)});
      @(negedge clk);
      e = sb.pop_front(); vectors++;
      if (obs() !== e.v) begin miscompares++; $display("FAIL %s: got %b want %b", e.name, obs(), e.v); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_fwd_ex_mem();
    test_load_use();
    test_store_after_load();
    test_zero_and_priority();
    test_mdu_done();
    test_done_ignored();
    test_done_on_timeout_cycle();
    test_timeout();
    test_rst_mid_mdu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
